hazard_fwd_ctrl: RTL

Pipeline hazard and forwarding controller for the 5-stage core. It tracks the destination and result source of each instruction in flight through EX, MEM and WB. From that state it drives the operand-forwarding selects for EX, the `{sel1,sel0}` selects of the MEM- and WB-stage 3-to-1 result muxes (ALU/load/PC), the load-use stall, the branch flush and the memory-wait freeze. It sits beside the ID/EX pipeline registers and consumes ID-stage decode fields.

---
 rtl/core_pkg.sv | 48 ++++
 rtl/fwd_select.sv | 24 ++
 rtl/hazard_fwd_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types for the hazard/forwarding controller: result-source and
// forward-select encodings, and the per-stage pipeline records.
package core_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC   = 2'b10
    } wb_src_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        wb_src_t    wb_src;
    } stage_rec_t;

    typedef struct packed {
        stage_rec_t base;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } ex_rec_t;

    // x0 is hardwired, so a write to it never produces a usable result.
    function automatic logic rec_wr(input stage_rec_t r);
        return r.valid && r.we && (r.rd != 5'd0);
    endfunction

    // The unused encoding 11 behaves as PC+4.
    function automatic wb_src_t norm_wb_src(input logic [1:0] src);
        wb_src_t res;
        case (src)
            2'b00:   res = WB_ALU;
            2'b01:   res = WB_LOAD;
            default: res = WB_PC;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Operand forward select for one EX source: the younger MEM producer wins
// over the older WB producer.
module fwd_select
    import core_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_rs_used,
    input  logic       i_mem_wr,
    input  logic [4:0] i_mem_rd,
    input  logic       i_wb_wr,
    input  logic [4:0] i_wb_rd,
    output fwd_sel_t   o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_rs_used && i_mem_wr && (i_mem_rd == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_rs_used && i_wb_wr && (i_wb_rd == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: tracks EX/MEM/WB
// records and derives forwarding, result-mux selects, stall, flush and freeze.
module hazard_fwd_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_rd_we,
    input  logic [1:0]       i_id_wb_src,
    input  logic             i_ex_branch_taken,
    input  logic             i_mem_busy,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_flush_ifid,
    output logic [1:0]       o_fwd_rs1_sel,
    output logic [1:0]       o_fwd_rs2_sel,
    output logic             o_mem_res_sel0,
    output logic             o_mem_res_sel1,
    output logic             o_wb_res_sel0,
    output logic             o_wb_res_sel1,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ex_rec_t          r_ex;
    stage_rec_t       r_mem;
    stage_rec_t       r_wb;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ex_rec_t    w_id_rec;
    logic       w_lu;
    logic       w_fl;
    logic       w_lu_stall;
    logic       w_mem_wr;
    logic       w_wb_wr;
    fwd_sel_t   w_fwd_rs1;
    fwd_sel_t   w_fwd_rs2;
    logic [1:0] w_mem_res;
    logic [1:0] w_wb_res;

    always_comb begin
        w_id_rec               = '0;
        w_id_rec.base.valid    = 1'b1;
        w_id_rec.base.rd       = i_id_rd;
        w_id_rec.base.we       = i_id_rd_we;
        w_id_rec.base.wb_src   = norm_wb_src(i_id_wb_src);
        w_id_rec.rs1           = i_id_rs1;
        w_id_rec.rs2           = i_id_rs2;
        w_id_rec.rs1_used      = i_id_rs1_used;
        w_id_rec.rs2_used      = i_id_rs2_used;
    end

    assign w_lu = i_id_valid && (r_ex.base.wb_src == WB_LOAD) && rec_wr(r_ex.base) &&
                  ((i_id_rs1_used && (i_id_rs1 == r_ex.base.rd)) ||
                   (i_id_rs2_used && (i_id_rs2 == r_ex.base.rd)));
    assign w_fl = i_ex_branch_taken && r_ex.base.valid && !i_mem_busy;

    // A squashed ID instruction must not also stall the front end.
    assign w_lu_stall = w_lu && !w_fl;

    assign o_stall_if   = i_mem_busy || w_lu_stall;
    assign o_stall_id   = i_mem_busy || w_lu_stall;
    assign o_flush_ifid = w_fl;

    assign w_mem_wr = rec_wr(r_mem);
    assign w_wb_wr  = rec_wr(r_wb);

    fwd_select u_fwd_rs1 (
        .i_rs      (r_ex.rs1),
        .i_rs_used (r_ex.rs1_used),
        .i_mem_wr  (w_mem_wr),
        .i_mem_rd  (r_mem.rd),
        .i_wb_wr   (w_wb_wr),
        .i_wb_rd   (r_wb.rd),
        .o_sel     (w_fwd_rs1)
    );

    fwd_select u_fwd_rs2 (
        .i_rs      (r_ex.rs2),
        .i_rs_used (r_ex.rs2_used),
        .i_mem_wr  (w_mem_wr),
        .i_mem_rd  (r_mem.rd),
        .i_wb_wr   (w_wb_wr),
        .i_wb_rd   (r_wb.rd),
        .o_sel     (w_fwd_rs2)
    );

    assign o_fwd_rs1_sel = w_fwd_rs1;
    assign o_fwd_rs2_sel = w_fwd_rs2;

    assign w_mem_res      = r_mem.valid ? r_mem.wb_src : 2'b00;
    assign w_wb_res       = r_wb.valid  ? r_wb.wb_src  : 2'b00;
    assign o_mem_res_sel0 = w_mem_res[0];
    assign o_mem_res_sel1 = w_mem_res[1];
    assign o_wb_res_sel0  = w_wb_res[0];
    assign o_wb_res_sel1  = w_wb_res[1];

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // A busy data memory freezes every record and both counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!i_mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex.base;
            if (w_fl || w_lu || !i_id_valid) begin
                r_ex <= '0;
            end else begin
                r_ex <= w_id_rec;
            end
            if (w_lu_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_fl && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

endmodule
